// File: rtl/icache_assoc.sv
// Set-associative instruction cache: combinational hits, true-LRU replacement, word-by-word block fill.
// Hit latency 0 cycles; a miss costs one miss cycle plus BLKWORDS*(k+1) fill cycles; a data-side request stalls the instruction side.
module icache_assoc #(
  parameter int WAYS     = 2,
  parameter int SETS     = 8,
  parameter int BLKWORDS = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  input  logic        dmemREN,
  input  logic        dmemWEN,
  input  logic        iflush,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload
);

  localparam int BO   = $clog2(BLKWORDS);
  localparam int OFFW = (BO > 0) ? BO : 1;
  localparam int IW   = $clog2(SETS);
  localparam int TW   = 30 - BO - IW;
  localparam int WW   = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic {IDLE, FILL} state_t;
  typedef logic [WAYS-1:0][WW-1:0] ages_t;

  logic          valid [WAYS][SETS];
  logic [TW-1:0] tags  [WAYS][SETS];
  logic [31:0]   data  [WAYS][SETS][BLKWORDS];
  ages_t         age   [SETS];

  state_t          state;
  logic [TW-1:0]   miss_tag;
  logic [IW-1:0]   miss_idx;
  logic [31:0]     miss_base;
  logic [OFFW-1:0] cnt;
  logic [WW-1:0]   victim;

  logic [TW-1:0]   cur_tag;
  logic [IW-1:0]   cur_idx;
  logic [OFFW-1:0] cur_off;
  logic            req;
  logic            hit_any;
  logic [WW-1:0]   hit_way;
  logic [WW-1:0]   vic_way;
  logic [WW-1:0]   sel_way;
  logic            last_word;

  assign cur_tag   = imemaddr[31 -: TW];
  assign cur_idx   = imemaddr[2+BO +: IW];
  assign cur_off   = (BO > 0) ? imemaddr[2 +: OFFW] : '0;
  assign req       = (state == IDLE) && imemREN && !dmemREN && !dmemWEN;
  assign last_word = (cnt == OFFW'(BLKWORDS - 1));

  always_comb begin
    hit_any = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!hit_any && valid[w][cur_idx] && (tags[w][cur_idx] == cur_tag)) begin
        hit_any = 1'b1;
        hit_way = WW'(w);
      end
    end
  end

  // Prefer the lowest invalid way; otherwise evict the oldest (age WAYS-1).
  always_comb begin
    logic found;
    found   = 1'b0;
    vic_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!found && !valid[w][cur_idx]) begin
        found   = 1'b1;
        vic_way = WW'(w);
      end
    end
    if (!found) begin
      for (int w = 0; w < WAYS; w++) begin
        if (age[cur_idx][w] == WW'(WAYS - 1)) vic_way = WW'(w);
      end
    end
  end

  assign ihit     = req && hit_any && !iflush;
  assign sel_way  = ihit ? hit_way : '0;
  assign imemload = data[sel_way][cur_idx][cur_off];
  assign iREN     = (state == FILL);
  assign iaddr    = (state == FILL) ? (miss_base | {{(30-OFFW){1'b0}}, cnt, 2'b00}) : 32'h0;

  function automatic ages_t lru_touch(input ages_t a, input logic [WW-1:0] way);
    ages_t r;
    r = a;
    for (int w = 0; w < WAYS; w++) begin
      if (WW'(w) == way)     r[w] = '0;
      else if (a[w] < a[way]) r[w] = a[w] + 1'b1;
    end
    return r;
  endfunction

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      miss_tag  <= '0;
      miss_idx  <= '0;
      miss_base <= '0;
      cnt       <= '0;
      victim    <= '0;
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          valid[w][s]  <= 1'b0;
          tags[w][s]   <= '0;
          age[s][w]    <= WW'(w);
          for (int b = 0; b < BLKWORDS; b++) data[w][s][b] <= '0;
        end
      end
    end else if (iflush) begin
      state <= IDLE;
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++) valid[w][s] <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req && hit_any) begin
            age[cur_idx] <= lru_touch(age[cur_idx], hit_way);
          end else if (req) begin
            miss_tag  <= cur_tag;
            miss_idx  <= cur_idx;
            miss_base <= {cur_tag, cur_idx, {(BO+2){1'b0}}};
            cnt       <= '0;
            victim    <= vic_way;
            // Drop the victim now so a half-written block can never hit.
            valid[vic_way][cur_idx] <= 1'b0;
            state     <= FILL;
          end
        end
        FILL: begin
          if (!iwait) begin
            data[victim][miss_idx][cnt] <= iload;
            cnt <= cnt + 1'b1;
            if (last_word) begin
              valid[victim][miss_idx] <= 1'b1;
              tags[victim][miss_idx]  <= miss_tag;
              age[miss_idx]           <= lru_touch(age[miss_idx], victim);
              state                   <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icache_assoc.sv
// Bench for icache_assoc: directed scenarios plus random traffic against a recency-list cache model.
module tb_icache_assoc;

  localparam int WAYS = 2;
  localparam int SETS = 8;
  localparam int BLKW = 2;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        imemREN = 1'b0;
  logic [31:0] imemaddr = 32'h0;
  logic        dmemREN = 1'b0;
  logic        dmemWEN = 1'b0;
  logic        iflush = 1'b0;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait = 1'b1;
  logic [31:0] iload = 32'h0;

  int total = 0;
  int bad   = 0;
  int wait_k = 0;

  icache_assoc #(.WAYS(WAYS), .SETS(SETS), .BLKWORDS(BLKW)) dut (
    .CLK(CLK), .RST(RST), .imemREN(imemREN), .imemaddr(imemaddr),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .iflush(iflush),
    .ihit(ihit), .imemload(imemload), .iREN(iREN), .iaddr(iaddr),
    .iwait(iwait), .iload(iload)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] memval(input logic [31:0] a);
    if (a == 32'h40) return 32'hAAAA0001;
    if (a == 32'h44) return 32'hAAAA0002;
    return {~a[15:0], a[15:0]};
  endfunction

  // Memory: each requested word is held busy for wait_k cycles, then accepted.
  int          wcnt = 0;
  bit          mem_active = 0;
  logic [31:0] mem_addr = 32'h0;
  always @(negedge CLK) begin
    if (iREN) begin
      if (!mem_active || iaddr != mem_addr) begin
        mem_active = 1;
        mem_addr   = iaddr;
        wcnt       = 0;
      end
      iwait = (wcnt < wait_k);
      iload = memval(iaddr);
      wcnt++;
    end else begin
      mem_active = 0;
      iwait = 1'b1;
      iload = 32'h0;
    end
  end

  // Model: per set, resident tags ordered most-recent first.
  logic [31:0] m_tag [SETS][WAYS];
  int          m_cnt [SETS];

  function automatic int set_of(input logic [31:0] a);
    return int'((a >> 3) % SETS);
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] a);
    return a >> 6;
  endfunction

  function automatic bit m_lookup(input logic [31:0] a);
    int s = set_of(a);
    for (int i = 0; i < m_cnt[s]; i++) if (m_tag[s][i] == tag_of(a)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic m_touch(input logic [31:0] a);
    int s = set_of(a);
    int p = 0;
    for (int i = 0; i < m_cnt[s]; i++) if (m_tag[s][i] == tag_of(a)) p = i;
    for (int i = p; i > 0; i--) m_tag[s][i] = m_tag[s][i-1];
    m_tag[s][0] = tag_of(a);
  endtask

  task automatic m_insert(input logic [31:0] a);
    int s = set_of(a);
    if (m_cnt[s] < WAYS) m_cnt[s]++;
    for (int i = m_cnt[s] - 1; i > 0; i--) m_tag[s][i] = m_tag[s][i-1];
    m_tag[s][0] = tag_of(a);
  endtask

  task automatic m_clear;
    for (int s = 0; s < SETS; s++) m_cnt[s] = 0;
  endtask

  // One instruction fetch; on a miss, follows the whole fill and checks the refill hit.
  task automatic access(input logic [31:0] a, input logic [31:0] alt, input bit use_alt);
    bit          eh;
    logic [31:0] base;
    @(negedge CLK);
    imemaddr = a; imemREN = 1'b1; dmemREN = 1'b0; dmemWEN = 1'b0;
    #2;
    eh = m_lookup(a);
    total++;
    if (ihit !== eh) begin bad++; $display("FAIL access_hit addr=%h got=%b exp=%b", a, ihit, eh); end
    if (eh) begin
      total++;
      if (imemload !== memval(a)) begin bad++; $display("FAIL hit_data addr=%h got=%h exp=%h", a, imemload, memval(a)); end
      total++;
      if (iREN !== 1'b0) begin bad++; $display("FAIL hit_iren addr=%h got=%b exp=0", a, iREN); end
      m_touch(a);
    end else begin
      base = a & 32'hFFFF_FFF8;
      for (int w = 0; w < BLKW; w++) begin
        for (int c = 0; c <= wait_k; c++) begin
          @(negedge CLK);
          if (use_alt) imemaddr = alt;
          #2;
          total++;
          if (iREN !== 1'b1 || iaddr !== base + 32'(4*w)) begin
            bad++; $display("FAIL fill_req addr=%h got iREN=%b iaddr=%h exp iREN=1 iaddr=%h", a, iREN, iaddr, base + 32'(4*w));
          end
          total++;
          if (ihit !== 1'b0) begin bad++; $display("FAIL fill_ihit addr=%h got=%b exp=0", a, ihit); end
        end
      end
      @(negedge CLK);
      imemaddr = a;
      #2;
      m_insert(a);
      total++;
      if (ihit !== 1'b1 || imemload !== memval(a)) begin
        bad++; $display("FAIL refill_hit addr=%h got ihit=%b data=%h exp ihit=1 data=%h", a, ihit, imemload, memval(a));
      end
      total++;
      if (iREN !== 1'b0) begin bad++; $display("FAIL refill_iren addr=%h got=%b exp=0", a, iREN); end
    end
  endtask

  task automatic do_flush;
    @(negedge CLK);
    imemREN = 1'b0; iflush = 1'b1;
    @(negedge CLK);
    iflush = 1'b0;
    m_clear();
  endtask

  task automatic test_reset;
    imemREN = 1'b1; imemaddr = 32'h40;
    #2;
    total++;
    if (ihit !== 1'b0 || iREN !== 1'b0) begin bad++; $display("FAIL reset_ctl got ihit=%b iREN=%b exp 0 0", ihit, iREN); end
    total++;
    if (iaddr !== 32'h0) begin bad++; $display("FAIL reset_iaddr got=%h exp=0", iaddr); end
    total++;
    if (imemload !== 32'h0) begin bad++; $display("FAIL reset_load got=%h exp=0", imemload); end
    repeat (2) @(negedge CLK);
    RST = 1'b0; imemREN = 1'b0;
    m_clear();
  endtask

  task automatic test_cold_miss;
    wait_k = 2;
    access(32'h40, 32'h0, 1'b0);
    access(32'h44, 32'h0, 1'b0);
    wait_k = 0;
  endtask

  task automatic test_lru;
    do_flush();
    access(32'h000, 32'h0, 1'b0);
    access(32'h040, 32'h0, 1'b0);
    access(32'h000, 32'h0, 1'b0);
    access(32'h080, 32'h0, 1'b0);
    access(32'h000, 32'h0, 1'b0);
    access(32'h080, 32'h0, 1'b0);
    access(32'h040, 32'h0, 1'b0);
  endtask

  task automatic test_dmem_block;
    access(32'h40, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      imemaddr = 32'h40; imemREN = 1'b1; dmemREN = (i != 1); dmemWEN = (i != 0);
      #2;
      total++;
      if (ihit !== 1'b0 || iREN !== 1'b0) begin bad++; $display("FAIL dmem_block cyc=%0d got ihit=%b iREN=%b exp 0 0", i, ihit, iREN); end
    end
    @(negedge CLK);
    dmemREN = 1'b0; dmemWEN = 1'b0;
    #2;
    total++;
    if (ihit !== 1'b1 || imemload !== 32'hAAAA0001) begin
      bad++; $display("FAIL dmem_release got ihit=%b data=%h exp 1 aaaa0001", ihit, imemload);
    end
    m_touch(32'h40);
  endtask

  task automatic test_addr_change;
    do_flush();
    access(32'h40, 32'h100, 1'b1);
    access(32'h40, 32'h0, 1'b0);
    access(32'h100, 32'h0, 1'b0);
  endtask

  task automatic test_flush;
    access(32'h40, 32'h0, 1'b0);
    wait_k = 1;
    @(negedge CLK);
    imemaddr = 32'h200; imemREN = 1'b1;
    #2;
    total++;
    if (ihit !== 1'b0) begin bad++; $display("FAIL flush_miss got=%b exp=0", ihit); end
    @(negedge CLK); #2;
    total++;
    if (iREN !== 1'b1 || iaddr !== 32'h200) begin bad++; $display("FAIL flush_fill1 got iREN=%b iaddr=%h exp 1 200", iREN, iaddr); end
    @(negedge CLK);
    iflush = 1'b1;
    #2;
    total++;
    if (iREN !== 1'b1 || ihit !== 1'b0) begin bad++; $display("FAIL flush_fill2 got iREN=%b ihit=%b exp 1 0", iREN, ihit); end
    @(negedge CLK);
    iflush = 1'b0; imemREN = 1'b0;
    #2;
    total++;
    if (iREN !== 1'b0 || iaddr !== 32'h0) begin bad++; $display("FAIL flush_abort got iREN=%b iaddr=%h exp 0 0", iREN, iaddr); end
    m_clear();
    wait_k = 0;
    access(32'h40, 32'h0, 1'b0);
    access(32'h200, 32'h0, 1'b0);
    @(negedge CLK);
    imemaddr = 32'h40; imemREN = 1'b1; iflush = 1'b1;
    #2;
    total++;
    if (ihit !== 1'b0) begin bad++; $display("FAIL flush_mask_ihit got=%b exp=0", ihit); end
    @(negedge CLK);
    iflush = 1'b0; imemREN = 1'b0;
    m_clear();
    access(32'h40, 32'h0, 1'b0);
    access(32'h200, 32'h0, 1'b0);
  endtask

  task automatic test_reset_mid_fill;
    @(negedge CLK);
    imemaddr = 32'h300; imemREN = 1'b1;
    @(negedge CLK); #2;
    total++;
    if (iREN !== 1'b1 || iaddr !== 32'h300) begin bad++; $display("FAIL rst_fill_start got iREN=%b iaddr=%h exp 1 300", iREN, iaddr); end
    #1 RST = 1'b1;
    #1;
    total++;
    if (iREN !== 1'b0 || iaddr !== 32'h0 || ihit !== 1'b0) begin
      bad++; $display("FAIL rst_async got iREN=%b iaddr=%h ihit=%b exp 0 0 0", iREN, iaddr, ihit);
    end
    @(negedge CLK);
    RST = 1'b0; imemREN = 1'b0;
    m_clear();
    access(32'h40, 32'h0, 1'b0);
  endtask

  task automatic test_random;
    logic [31:0] a;
    for (int n = 0; n < 300; n++) begin
      int r = $urandom_range(0, 19);
      if (r == 0) begin
        do_flush();
      end else if (r == 1) begin
        @(negedge CLK);
        imemaddr = {$urandom_range(0, 3), 6'b0} | ($urandom_range(0, 1) << 3);
        imemREN = 1'b1; dmemREN = 1'b1;
        #2;
        total++;
        if (ihit !== 1'b0) begin bad++; $display("FAIL rand_block addr=%h got=%b exp=0", imemaddr, ihit); end
        @(negedge CLK);
        dmemREN = 1'b0; imemREN = 1'b0;
        #2;
        total++;
        if (iREN !== 1'b0) begin bad++; $display("FAIL rand_block_iren got=%b exp=0", iREN); end
      end else begin
        wait_k = $urandom_range(0, 2);
        a = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 1) << 3) | ($urandom_range(0, 1) << 2);
        access(a, 32'h0, 1'b0);
      end
    end
    wait_k = 0;
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_lru();
    test_dmem_block();
    test_addr_change();
    test_flush();
    test_reset_mid_fill();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/icache_assoc.md
# icache_assoc

Parametrised set-associative instruction cache, next generation of the direct-mapped icache. It sits between the datapath instruction port and the memory-side icache port of the caches interface. It adds configurable ways, sets and words per block, true-LRU replacement, a latched miss address and a whole-cache invalidate. Hits are served combinationally in the same cycle. Misses fill a full block word by word from memory.

## Interface
- WAYS, 2: associativity; legal values 1, 2, 4.
- SETS, 8: sets per way; power of 2, at least 2.
- BLKWORDS, 2: 32-bit words per block; power of 2, at least 1.
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  asynchronous, active-high reset.
- imemREN  in  1  datapath instruction read request.
- imemaddr  in  32  instruction byte address, word aligned.
- dmemREN, dmemWEN  in  1 each  datapath data request; any high blocks the instruction side.
- iflush  in  1  invalidate all lines.
- ihit  out  1  instruction valid on imemload this cycle.
- imemload  out  32  instruction word.
- iREN  out  1  memory read request.
- iaddr  out  32  memory word address.
- iwait  in  1  memory busy; the word on iload is accepted when low.
- iload  in  32  memory read data.

## Operation
- Address split: [1:0] byte offset (ignored). [BO+1:2] word-in-block, BO = log2(BLKWORDS). Next log2(SETS) bits are the index. The remainder is the tag.
- Storage per line: valid, tag, BLKWORDS data words.
- Storage per set: one age field per way, log2(WAYS) bits each.
- Hit, in IDLE only: imemREN=1, dmemREN=0, dmemWEN=0, and some way in the set is valid with a matching tag.
  - ihit=1 and imemload = that way's addressed word.
  - LRU update on the same edge: the hit way's age becomes 0; ways whose age was smaller than it increment.
- Miss: the same request conditions with no hit.
  - On the next edge: latch tag, index and base address into the miss registers, clear the word counter, enter FILL.
- Victim selection, at the transition into FILL:
  - Lowest-numbered invalid way.
  - If none is invalid, the way with age WAYS-1.
  - Latch the victim.
- FILL:
  - iREN=1; iaddr = {miss tag, miss index, word counter, 2'b00}.
  - Each cycle with iwait=0: write iload into the victim's word[counter] and increment the counter.
  - On the last word: set victim valid and tag, apply the LRU update for the victim, return to IDLE.
  - imemaddr and imemREN are ignored during FILL; the fill always completes.
- Victim valid stays 0 throughout FILL, so a partial block never hits.
- imemload outside a hit: word of way 0 at the current index and offset. It is don't-care but deterministic.
- iflush=1: all valid bits clear on the next edge and state goes to IDLE, aborting any fill.
  - ihit is forced to 0 in the cycle iflush is high.
- WAYS=1 degenerates to direct-mapped; age fields are unused.

## Timing
- States: IDLE and FILL.
  - IDLE to FILL on a miss.
  - FILL to IDLE after the last accepted word, or on iflush.
  - Any state to IDLE on RST.
- Reset, immediate and asynchronous:
  - All valid bits 0, tags and data 0; age of way w = w.
  - State IDLE; miss registers and counter 0.
  - ihit=0, iREN=0, iaddr=0, imemload=0.
- Hit latency: 0 cycles, combinational from imemaddr.
- Miss latency with a memory wait of k cycles per word:
  - Miss cycle, then BLKWORDS*(k+1) FILL cycles, then a hit in the first IDLE cycle.
  - Example: BLKWORDS=2, k=0 gives ihit 3 cycles after the miss cycle.
- iREN is held continuously for the whole FILL and never deasserts between words.
  - iaddr changes only on an edge where a word is accepted.
- iflush has priority over fill completion and over miss detection on the same edge.

## Test plan
- **Cold miss.** Defaults; read 0x00000040 with iwait high for 2 cycles per word; iload 0xAAAA0001 then 0xAAAA0002.
  - Required: iaddr 0x40 then 0x44, with iREN held high.
  - Required: afterwards ihit=1, imemload=0xAAAA0001 at 0x40.
  - Required: 0x44 hits with 0xAAAA0002 and no iREN.
- **LRU eviction.** Fill 0x000 then 0x040 (same set, tags 0 and 1); hit 0x000; miss 0x080.
  - Required: tag 1 is evicted.
  - Required: 0x000 and 0x080 hit; 0x040 misses.
- **Data-side blocking.** Valid line at 0x40 with imemREN=1 and dmemREN=1.
  - Required: ihit=0 and no FILL entry.
  - Required: dmemREN drops, then ihit=1 the same cycle.
- **Address change mid-fill.** Miss at 0x40; imemaddr moves to 0x100 during FILL.
  - Required: iaddr stays on the 0x40/0x44 sequence.
  - Required: afterwards 0x40 hits and 0x100 starts a new miss.
- **Flush.** iflush pulsed in the second FILL cycle.
  - Required: iREN=0 on the next cycle and state IDLE.
  - Required: all previously resident addresses miss.
- **Reset mid-fill.** RST asserted while iREN=1.
  - Required: iREN, iaddr and ihit go to 0 without a clock edge.
  - Required: after release, 0x40 misses.
